// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB-first, even parity, one stop bit.
// Generates its own 16x oversampling tick from baud_select and flags parity/framing errors.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    // Wide enough for the slowest rate (300 baud) divisor.
    localparam int unsigned CntW = $clog2(CLK_HZ / 4800 + 2);

    function automatic logic [CntW-1:0] div_of(input int unsigned baud);
        return CntW'((CLK_HZ + 8 * baud) / (16 * baud));
    endfunction

    localparam logic [CntW-1:0] DivTable [8] = '{
        div_of(300),   div_of(1200),  div_of(4800),  div_of(9600),
        div_of(19200), div_of(38400), div_of(57600), div_of(115200)
    };

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t          state;
    logic            rxd_meta, rxd_sync, rxd_prev;
    logic [2:0]      baud_q;
    logic [CntW-1:0] tick_cnt;
    logic [CntW-1:0] div;
    logic            tick;
    logic [3:0]      sample_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            perr;
    logic            mid_bit;

    assign div     = DivTable[baud_q];
    assign tick    = (tick_cnt == div - CntW'(1));
    // Data/parity/stop samples land 16 ticks apart, starting from the mid-start sample.
    assign mid_bit = tick && (sample_cnt == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rxd_prev   <= 1'b1;
            baud_q     <= 3'd0;
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            perr       <= 1'b0;
            Rx_DATA    <= 8'h00;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            Rx_VALID <= 1'b0;

            if (!Rx_EN) begin
                state      <= StIdle;
                tick_cnt   <= '0;
                sample_cnt <= 4'd0;
                bit_cnt    <= 3'd0;
            end else begin
                if (state != StIdle) begin
                    tick_cnt <= tick ? '0 : tick_cnt + CntW'(1);
                end
                if (state != StIdle && tick) begin
                    sample_cnt <= sample_cnt + 4'd1;
                end

                case (state)
                    StIdle: begin
                        if (rxd_prev && !rxd_sync) begin
                            state      <= StStart;
                            baud_q     <= baud_select;
                            tick_cnt   <= '0;
                            sample_cnt <= 4'd0;
                        end
                    end
                    StStart: begin
                        if (tick && sample_cnt == 4'd7) begin
                            sample_cnt <= 4'd0;
                            bit_cnt    <= 3'd0;
                            state      <= rxd_sync ? StIdle : StData;
                        end
                    end
                    StData: begin
                        if (mid_bit) begin
                            shift_reg <= {rxd_sync, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= StParity;
                            end
                        end
                    end
                    StParity: begin
                        if (mid_bit) begin
                            perr  <= rxd_sync ^ (^shift_reg);
                            state <= StStop;
                        end
                    end
                    StStop: begin
                        // Leaving at mid-stop lets a back-to-back start edge be caught.
                        if (mid_bit) begin
                            Rx_DATA   <= shift_reg;
                            Rx_PERROR <= perr;
                            Rx_FERROR <= ~rxd_sync;
                            Rx_VALID  <= 1'b1;
                            state     <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a frame-level model predicts each delivered byte,
// its error flags and its arrival window; outputs are compared every cycle.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int unsigned Bit7 = 432;   // 50 MHz / 115200 baud, 16 x 27 clk
    localparam int unsigned Bit3 = 5216;  // 50 MHz / 9600 baud, 16 x 326 clk

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RxD = 1'b1;
    logic       Rx_EN = 1'b0;
    logic [2:0] baud_select = 3'd7;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned nvalid = 0;

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned lo;
        int unsigned hi;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     cur;
    logic [7:0] held_data = 8'h00;
    logic       held_perr = 1'b0;
    logic       held_ferr = 1'b0;

    uart_receiver #(.CLK_HZ(50000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .RxD        (RxD),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Every cycle: a pulse must match the oldest predicted frame inside its window;
    // otherwise outputs must hold the last delivered frame.
    always @(negedge clk) begin
        if (Rx_VALID) begin
            nvalid++;
            chk("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("valid_data", Rx_DATA, cur.data);
                chk("valid_perror", Rx_PERROR, cur.perr);
                chk("valid_ferror", Rx_FERROR, cur.ferr);
                chk("valid_window", 32'(cyc >= cur.lo && cyc <= cur.hi), 1);
                held_data = cur.data;
                held_perr = cur.perr;
                held_ferr = cur.ferr;
            end
        end else begin
            chk("hold_data", Rx_DATA, held_data);
            chk("hold_perror", Rx_PERROR, held_perr);
            chk("hold_ferror", Rx_FERROR, held_ferr);
            if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
                chk("valid_by_deadline", Rx_VALID, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // abort: 0 none, 1 reset at data bit 4, 2 Rx_EN=0 at data bit 4, 3 baud change at data bit 4
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int unsigned bitc, input int abort);
        logic [10:0] bits;
        frame_t      f;
        bits = {stop, par, data, 1'b0};
        if (abort == 0 || abort == 3) begin
            f.data = data;
            f.perr = par ^ (^data);
            f.ferr = ~stop;
            f.lo   = cyc + 10 * bitc;
            f.hi   = cyc + 11 * bitc;
            exp_q.push_back(f);
        end
        for (int i = 0; i < 11; i++) begin
            if (i == 5 && abort == 1) begin
                reset = 1'b1;
                held_data = 8'h00;
                held_perr = 1'b0;
                held_ferr = 1'b0;
                exp_q.delete();
            end
            if (i == 5 && abort == 2) Rx_EN = 1'b0;
            if (i == 5 && abort == 3) baud_select = 3'd3;
            RxD = bits[i];
            repeat (bitc) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int unsigned nclk);
        RxD = 1'b1;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    int unsigned n0;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("reset_data", Rx_DATA, 8'h00);
        chk("reset_valid", Rx_VALID, 0);
        chk("reset_perror", Rx_PERROR, 0);
        chk("reset_ferror", Rx_FERROR, 0);
        reset = 1'b0;
        Rx_EN = 1'b1;
        idle(20);

        // Nominal: 0xA5 has four ones, parity bit 0 is correct.
        send_frame(8'hA5, 1'b0, 1'b1, Bit7, 0);
        chk("nominal_data", Rx_DATA, 8'hA5);
        chk("nominal_perror", Rx_PERROR, 0);
        chk("nominal_count", nvalid, 1);
        idle(Bit7);

        // 0x3C has four ones; parity bit 1 is wrong.
        send_frame(8'h3C, 1'b1, 1'b1, Bit7, 0);
        chk("perr_data", Rx_DATA, 8'h3C);
        chk("perr_flag", Rx_PERROR, 1);
        chk("perr_ferror", Rx_FERROR, 0);
        idle(Bit7);

        // Stop bit low, then line returns high; no start inferred from the held-low line.
        send_frame(8'h01, 1'b1, 1'b0, Bit7, 0);
        chk("ferr_data", Rx_DATA, 8'h01);
        chk("ferr_flag", Rx_FERROR, 1);
        idle(Bit7);
        chk("ferr_no_extra", nvalid, 3);
        send_frame(8'h02, 1'b1, 1'b1, Bit7, 0);
        chk("ferr_clear_data", Rx_DATA, 8'h02);
        chk("ferr_clear_flag", Rx_FERROR, 0);
        idle(Bit7);

        // False start at 9600 baud: 2000 clk glitch is shorter than half a bit.
        baud_select = 3'd3;
        idle(20);
        n0 = nvalid;
        RxD = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        idle(2 * Bit3);
        chk("false_start_no_valid", nvalid, n0);

        // Baud change mid-frame must not affect the frame in progress.
        baud_select = 3'd7;
        idle(20);
        send_frame(8'hFF, 1'b0, 1'b1, Bit7, 3);
        chk("ff_data", Rx_DATA, 8'hFF);
        baud_select = 3'd7;
        idle(Bit7);

        // Back-to-back frames with no idle gap.
        n0 = nvalid;
        send_frame(8'h55, 1'b0, 1'b1, Bit7, 0);
        send_frame(8'hC3, 1'b0, 1'b1, Bit7, 0);
        chk("b2b_count", nvalid, n0 + 2);
        chk("b2b_data", Rx_DATA, 8'hC3);
        idle(Bit7);

        // Reset at data bit 4, held until the line is idle again.
        n0 = nvalid;
        send_frame(8'h81, 1'b0, 1'b1, Bit7, 1);
        chk("reset_mid_data", Rx_DATA, 8'h00);
        idle(Bit7);
        reset = 1'b0;
        idle(Bit7);
        chk("reset_mid_no_valid", nvalid, n0);

        send_frame(8'h5A, 1'b0, 1'b1, Bit7, 0);
        idle(Bit7);

        // Disable at data bit 4: outputs hold 0x5A, no pulse.
        n0 = nvalid;
        send_frame(8'h81, 1'b0, 1'b1, Bit7, 2);
        idle(Bit7);
        Rx_EN = 1'b1;
        idle(Bit7);
        chk("disable_hold_data", Rx_DATA, 8'h5A);
        chk("disable_no_valid", nvalid, n0);
        send_frame(8'h81, 1'b0, 1'b1, Bit7, 0);
        chk("after_disable_data", Rx_DATA, 8'h81);
        idle(Bit7);

        chk("pending_frames", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive stage that sits directly downstream of the transmitter. It consumes the serial line driven by uart_transmitter's TxD and recovers the byte. Frame format is 11 bits: start=0, 8 data bits LSB-first, even parity (^data), stop=1. It delivers the byte with a one-clock valid strobe plus parity and framing error flags. It generates its own 16x oversampling tick from baud_select, so it needs no external baud controller.

Parameters:
CLK_HZ, 50000000, system clock frequency; used to compute tick divisors at elaboration.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, asynchronous, active-high
RxD  in  1  serial input; asynchronous to clk
baud_select  in  3  0..7 -> 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud
Rx_EN  in  1  receiver enable
Rx_DATA  out  8  last received byte
Rx_VALID  out  1  one-clk pulse when a frame completes
Rx_PERROR  out  1  parity error of last frame
Rx_FERROR  out  1  framing error (stop bit sampled 0) of last frame

Behaviour:
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, FSM=IDLE, tick counter=0, RxD sync flops=1.
- Synchronizer: RxD passes through 2 flops before any use, adding 2 clk of latency.
- Tick divisor: div = CLK_HZ/(16*baud), rounded to nearest. At 50 MHz the values are 10417, 2604, 651, 326, 163, 81, 54, 27.
- Tick generation: a 1-clk tick pulse fires every div clocks. The divider runs only outside IDLE and restarts at 0 on IDLE->START.
- baud_select is latched on IDLE->START and held for the whole frame. A change mid-frame takes effect on the next frame.
- Each bit period is 16 ticks, counted by a 4-bit sample counter.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a synchronized falling edge (1->0) with Rx_EN=1, go to START with the sample counter at 0.
- START: at sample count 7 (mid-bit), if the line is 1 it is a false start: return to IDLE with no output change. If the line is 0, reset the counter and go to DATA.
- DATA: sample at counts 15 past the start mid-point (i.e. every 16 ticks from the start sample). Shift the bit into the shift register LSB-first. After 8 bits, go to PARITY.
- PARITY: sample one bit; perr = sampled ^ (^shift_reg).
- STOP: sample one bit. On the following clk:
  - Rx_DATA <= shift_reg
  - Rx_PERROR <= perr
  - Rx_FERROR <= ~sampled
  - Rx_VALID = 1 for exactly 1 clk
  - FSM -> IDLE
- Rx_VALID also pulses on errored frames; data is delivered regardless of errors.
- Back-to-back frames: returning to IDLE at mid-stop allows detection of a start edge immediately after the stop bit.
- Framing error case: if stop is sampled 0, the FSM still returns to IDLE. The line is already low, so IDLE waits for the next 1->0 edge; no start is inferred from a held-low line.
- Rx_EN=0: FSM is forced to IDLE within 1 clk, any frame in progress is discarded, and counters clear. Rx_DATA/flags hold their values, Rx_VALID=0.
- Outputs hold their values until the next completed frame; there is no read acknowledge and no overrun detection.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.
- Latency: Rx_VALID asserts at 2 (sync) + 1 clk after the mid-stop sample tick, approximately 10.5 bit periods after the start edge.

Test Plan:
- Nominal frame: baud_select=7, Rx_EN=1; drive frame for 8'hA5 (parity bit 0), bit=432 clk -> one Rx_VALID pulse, Rx_DATA=8'hA5, PERROR=0, FERROR=0.
- Parity error: send 8'h3C with parity bit 1 -> Rx_VALID pulse, Rx_DATA=8'h3C, PERROR=1, FERROR=0.
- Framing error: send 8'h01 with stop=0, then line=1 -> Rx_DATA=8'h01, FERROR=1. Then send 8'h02 cleanly -> FERROR=0, Rx_DATA=8'h02.
- False start: baud_select=3 (bit=5216 clk); 0-glitch of 2000 clk then line=1 -> no Rx_VALID, FSM back in IDLE. Then 8'hFF frame -> Rx_DATA=8'hFF.
- Back-to-back and loopback: connect uart_transmitter TxD -> RxD, both baud_select=7; send 8'h55 then 8'hC3 -> two Rx_VALID pulses in order with matching data, no errors.
- Reset/enable mid-frame: assert reset at data bit 4 of 8'h81 -> all outputs 0, no Rx_VALID. Repeat with Rx_EN=0 mid-frame -> outputs hold previous values, no pulse, and the next full frame is received correctly.
